audio_rec_ctrl: RTL and testbench

Record/playback sequencer for the audio codec datapath. It captures codec samples into a single-port synchronous sample RAM on each `sample_end` strobe. It replays stored samples to the codec output path on each `sample_req` strobe, with optional looping. It owns the RAM address and write-enable and arbitrates record and play commands from the board keys.

---
 rtl/audio_rec_ctrl_if.sv | 58 +++++
 rtl/audio_rec_ctrl.sv | 130 +++++++++++++
 tb/tb_audio_rec_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_rec_ctrl_if.sv
// Signal bundle between the record/playback sequencer, the board keys, the codec path
// and the sample RAM.
interface audio_rec_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start_rec;
  logic                  start_play;
  logic                  stop;
  logic                  loop_en;
  logic                  sample_end;
  logic                  sample_req;
  logic [DATA_WIDTH-1:0] audio_in;
  logic [DATA_WIDTH-1:0] audio_out;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH:0]   rec_len;
  logic [1:0]            state;
  logic                  rec_full;

  modport master (
    output start_rec,
    output start_play,
    output stop,
    output loop_en,
    output sample_end,
    output sample_req,
    output audio_in,
    output mem_rdata,
    input  audio_out,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  rec_len,
    input  state,
    input  rec_full
  );

  modport slave (
    input  start_rec,
    input  start_play,
    input  stop,
    input  loop_en,
    input  sample_end,
    input  sample_req,
    input  audio_in,
    input  mem_rdata,
    output audio_out,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output rec_len,
    output state,
    output rec_full
  );
endinterface

// File: rtl/audio_rec_ctrl.sv
// Record/playback sequencer: writes codec samples into a single-port sample RAM and
// replays them to the codec, optionally looping.
module audio_rec_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  audio_rec_ctrl_if.slave  bus_io
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StPrime  = 2'd2,
    StPlay   = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0]   FullCount = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LenOne    = 1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne   = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] audio_out_q, audio_out_d;
  logic [ADDR_WIDTH:0]   rec_len_q, rec_len_d;
  logic                  last_sample;

  // The write pointer is the low bits of rec_len: every write advances both together.
  assign last_sample = ({1'b0, mem_addr_q} == (rec_len_q - LenOne));

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    audio_out_d = audio_out_q;
    rec_len_d   = rec_len_q;

    case (state_q)
      StIdle: begin
        if (bus_io.stop) begin
          audio_out_d = '0;
        end else if (bus_io.start_rec) begin
          state_d     = StRecord;
          rec_len_d   = '0;
          audio_out_d = '0;
        end else if (bus_io.start_play && (rec_len_q != '0)) begin
          state_d    = StPrime;
          mem_addr_d = '0;
        end
      end

      StRecord: begin
        if (bus_io.stop) begin
          state_d     = StIdle;
          audio_out_d = '0;
        end else if (bus_io.sample_end) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = rec_len_q[ADDR_WIDTH-1:0];
          mem_wdata_d = bus_io.audio_in;
          rec_len_d   = rec_len_q + LenOne;
          if (rec_len_d == FullCount) begin
            state_d = StIdle;
          end
        end
      end

      StPrime: begin
        // RAM read of mem_addr lands this cycle; any sample_req here is dropped.
        if (bus_io.stop) begin
          state_d     = StIdle;
          audio_out_d = '0;
        end else begin
          state_d = StPlay;
        end
      end

      StPlay: begin
        if (bus_io.stop) begin
          state_d     = StIdle;
          audio_out_d = '0;
        end else if (bus_io.sample_req) begin
          audio_out_d = bus_io.mem_rdata;
          mem_addr_d  = mem_addr_q + AddrOne;
          if (last_sample) begin
            if (bus_io.loop_en) begin
              mem_addr_d = '0;
              state_d    = StPrime;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      audio_out_q <= '0;
      rec_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      audio_out_q <= audio_out_d;
      rec_len_q   <= rec_len_d;
    end
  end

  assign bus_io.state     = state_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.audio_out = audio_out_q;
  assign bus_io.rec_len   = rec_len_q;
  // rec_len only reaches its MSB at exactly 2^ADDR_WIDTH.
  assign bus_io.rec_full  = rec_len_q[ADDR_WIDTH];

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Directed bench for audio_rec_ctrl with a RAM model; expected writes and playback
// samples are queued by the stimulus and checked by a monitor.
module tb_audio_rec_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_rec_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  audio_rec_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    out_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic req_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a captured sample_req must show its queued audio_out; every mem_we pulse
  // must match the next queued write.
  always @(posedge clk) begin
    req_hit = bus.sample_req;
    @(negedge clk);
    if (req_hit) begin
      if (out_q.size() == 0) begin
        n_checks++;
        $display("FAIL audio_out: got 0x%0h with no expected sample queued", bus.audio_out);
      end else begin
        check("audio_out", 32'(bus.audio_out), 32'(out_q.pop_front()));
      end
    end
    if (bus.mem_we) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        $display("FAIL write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check("write_addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cmd(input logic rec, input logic play, input logic stp);
    bus.start_rec  = rec;
    bus.start_play = play;
    bus.stop       = stp;
    tick();
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    bus.stop       = 1'b0;
  endtask

  task automatic rec_sample(input logic [DW-1:0] d, input logic wr, input logic [AW-1:0] a);
    bus.audio_in   = d;
    bus.sample_end = 1'b1;
    if (wr) wr_q.push_back({a, d});
    tick();
    bus.sample_end = 1'b0;
  endtask

  task automatic req(input logic [DW-1:0] exp);
    out_q.push_back(exp);
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    bus.stop       = 1'b0;
    bus.loop_en    = 1'b0;
    bus.sample_end = 1'b0;
    bus.sample_req = 1'b0;
    bus.audio_in   = '0;
    idle(3);
    reset = 1'b0;
    tick();
    check("reset_state", 32'(bus.state), 0);
    check("reset_rec_len", 32'(bus.rec_len), 0);
    check("reset_audio_out", 32'(bus.audio_out), 0);
    check("reset_mem_addr", 32'(bus.mem_addr), 0);
    check("reset_mem_we", 32'(bus.mem_we), 0);
    check("reset_rec_full", 32'(bus.rec_full), 0);

    // Record five samples, then stop.
    cmd(1'b1, 1'b0, 1'b0);
    check("rec_state", 32'(bus.state), 1);
    for (int i = 0; i < 5; i++) begin
      idle(3);
      rec_sample(DW'(16'h1000 + i), 1'b1, AW'(i));
      check("rec_len_step", 32'(bus.rec_len), 32'(i + 1));
    end
    idle(3);
    cmd(1'b0, 1'b0, 1'b1);
    check("rec_stop_state", 32'(bus.state), 0);
    check("rec5_len", 32'(bus.rec_len), 5);
    check("rec5_full", 32'(bus.rec_full), 0);

    // Play without loop: sixth request must leave audio_out unchanged.
    cmd(1'b0, 1'b1, 1'b0);
    check("play_prime", 32'(bus.state), 2);
    tick();
    check("play_play", 32'(bus.state), 3);
    for (int i = 0; i < 6; i++) begin
      idle(3);
      req((i < 5) ? DW'(16'h1000 + i) : DW'(16'h1004));
      if (i == 4) check("play_end_idle", 32'(bus.state), 0);
    end
    check("play_after_extra", 32'(bus.state), 0);

    // Loop playback: request in the first PRIME is dropped, then two full passes.
    idle(3);
    bus.loop_en = 1'b1;
    cmd(1'b0, 1'b1, 1'b0);
    check("loop_prime", 32'(bus.state), 2);
    req(16'h1004);
    check("loop_play", 32'(bus.state), 3);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 5; i++) begin
        idle(3);
        req(DW'(16'h1000 + i));
        if (i == 4) check("loop_wrap_prime", 32'(bus.state), 2);
      end
      tick();
      check("loop_replay", 32'(bus.state), 3);
    end
    idle(3);
    cmd(1'b0, 1'b0, 1'b1);
    check("loop_stop_state", 32'(bus.state), 0);
    check("loop_stop_audio", 32'(bus.audio_out), 0);
    bus.loop_en = 1'b0;

    // Priority: record beats play; stop beats sample_end; play needs data.
    idle(3);
    cmd(1'b1, 1'b1, 1'b0);
    check("both_start_rec", 32'(bus.state), 1);
    check("both_start_len", 32'(bus.rec_len), 0);
    idle(3);
    bus.audio_in   = 16'hdead;
    bus.sample_end = 1'b1;
    bus.stop       = 1'b1;
    tick();
    bus.sample_end = 1'b0;
    bus.stop       = 1'b0;
    check("stop_end_state", 32'(bus.state), 0);
    check("stop_end_len", 32'(bus.rec_len), 0);
    cmd(1'b0, 1'b1, 1'b0);
    check("play_empty_state", 32'(bus.state), 0);

    // Full: 20 strobes, only 16 written, auto return to IDLE.
    cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      idle(3);
      rec_sample(DW'(16'h2000 + i), (i < 16), AW'(i));
      if (i == 15) begin
        check("full_idle", 32'(bus.state), 0);
        check("full_flag", 32'(bus.rec_full), 1);
        check("full_len", 32'(bus.rec_len), 16);
      end
    end
    check("full_len_after", 32'(bus.rec_len), 16);
    idle(2);
    check("all_writes_seen", 32'(wr_q.size()), 0);

    // Asynchronous reset in the middle of playback.
    cmd(1'b0, 1'b1, 1'b0);
    tick();
    idle(3);
    req(16'h2000);
    idle(2);
    #2 reset = 1'b1;
    #1;
    check("areset_state", 32'(bus.state), 0);
    check("areset_audio", 32'(bus.audio_out), 0);
    check("areset_addr", 32'(bus.mem_addr), 0);
    check("areset_len", 32'(bus.rec_len), 0);
    check("areset_full", 32'(bus.rec_full), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    cmd(1'b0, 1'b1, 1'b0);
    check("post_reset_play", 32'(bus.state), 0);

    idle(2);
    check("all_samples_seen", 32'(out_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
